// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the framed PISO transmitter.
// Included by the serializer top and its bit timer.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit.
// bit_tick marks the last cycle of each bit period.
module bit_timer
    import piso_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    // Cycle counter, wraps to 0 at every bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Framed parallel-in serial-out transmitter (start, data, stop).
// Line idles high; words are loaded via a valid/ready handshake.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW = cnt_width(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nx;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_nx;
    logic                  line_nx;
    logic                  accept;
    logic                  timer_clear;
    logic                  bit_tick;

    assign accept      = tx_valid && tx_ready;
    assign timer_clear = (state == ST_IDLE);
    assign tx_busy     = !tx_ready;
    assign tx_done     = (state == ST_STOP) && bit_tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    // Next state, shift register, and the line level for next cycle.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        line_nx    = LINE_IDLE;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_START;
                    shreg_nx = tx_data;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_nx   = ST_DATA;
                    bit_cnt_nx = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (MSB_FIRST != 0) begin
                        shreg_nx = shreg << 1;
                    end else begin
                        shreg_nx = shreg >> 1;
                    end
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        unique case (state_nx)
            ST_IDLE:  line_nx = LINE_IDLE;
            ST_START: line_nx = START_BIT;
            ST_DATA: begin
                if (MSB_FIRST != 0) begin
                    line_nx = shreg_nx[DATA_WIDTH-1];
                end else begin
                    line_nx = shreg_nx[0];
                end
            end
            ST_STOP:  line_nx = STOP_BIT;
            default:  line_nx = LINE_IDLE;
        endcase
    end

    // State, datapath and registered line/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            serial_out <= LINE_IDLE;
            tx_ready   <= 1'b1;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_cnt    <= bit_cnt_nx;
            serial_out <= line_nx;
            tx_ready   <= (state_nx == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer.
// u0: 8 bits, 4 clks/bit, LSB first; u1: 8 bits, 1 clk/bit, MSB first.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       rdy0, so0, bsy0, dn0;
    logic       rdy1, so1, bsy1, dn1;

    int n_cmp = 0;
    int n_bad = 0;

    piso_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
        .serial_out(so0), .tx_busy(bsy0), .tx_done(dn0)
    );

    piso_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
        .serial_out(so1), .tx_busy(bsy1), .tx_done(dn1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        d0 = 8'h00; d1 = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({so0, rdy0, bsy0, dn0} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_u0 got %b want 1100",
                     {so0, rdy0, bsy0, dn0});
        end
        n_cmp++;
        if ({so1, rdy1, bsy1, dn1} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_u1 got %b want 1100",
                     {so1, rdy1, bsy1, dn1});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({so0, rdy0, bsy0, dn0, so1, rdy1, bsy1, dn1}
                !== 8'b1100_1100) begin
                n_bad++;
                $display("FAIL idle_hold cyc %0d got %b want 11001100",
                         i, {so0, rdy0, bsy0, dn0,
                             so1, rdy1, bsy1, dn1});
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        exp = 10'b1101001010;
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_ready_pre got %b want 1", rdy0);
        end
        d0 = 8'hA5; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            n_cmp++;
            if (so0 !== exp[(c-1)/4]) begin
                n_bad++;
                $display("FAIL basic_line cyc %0d got %b want %b",
                         c, so0, exp[(c-1)/4]);
            end
            n_cmp++;
            if (dn0 !== (c == 40)) begin
                n_bad++;
                $display("FAIL basic_done cyc %0d got %b want %b",
                         c, dn0, (c == 40));
            end
            n_cmp++;
            if ({rdy0, bsy0} !== 2'b01) begin
                n_bad++;
                $display("FAIL basic_busy cyc %0d got %b want 01",
                         c, {rdy0, bsy0});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({so0, rdy0, bsy0, dn0} !== 4'b1100) begin
            n_bad++;
            $display("FAIL basic_after got %b want 1100",
                     {so0, rdy0, bsy0, dn0});
        end
    endtask

    task automatic test_msb_first();
        logic [9:0] exp;
        exp = 10'b1100000010;
        @(negedge clk);
        d1 = 8'h81; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            n_cmp++;
            if (so1 !== exp[c-1]) begin
                n_bad++;
                $display("FAIL msb_line cyc %0d got %b want %b",
                         c, so1, exp[c-1]);
            end
            n_cmp++;
            if (dn1 !== (c == 10)) begin
                n_bad++;
                $display("FAIL msb_done cyc %0d got %b want %b",
                         c, dn1, (c == 10));
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({so1, rdy1, dn1} !== 3'b110) begin
            n_bad++;
            $display("FAIL msb_after got %b want 110",
                     {so1, rdy1, dn1});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp1, exp2;
        logic       el, er, ed;
        int         ndone;
        exp1  = 10'b1001111000;
        exp2  = 10'b1110000110;
        ndone = 0;
        @(negedge clk);
        d0 = 8'h3C; v0 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 81; c++) begin
            if (c <= 40) begin
                el = exp1[(c-1)/4]; er = 1'b0;
            end else if (c == 41) begin
                el = 1'b1; er = 1'b1;
            end else begin
                el = exp2[(c-42)/4]; er = 1'b0;
            end
            ed = (c == 40) || (c == 81);
            n_cmp++;
            if ({so0, rdy0, dn0} !== {el, er, ed}) begin
                n_bad++;
                $display("FAIL b2b cyc %0d got %b want %b",
                         c, {so0, rdy0, dn0}, {el, er, ed});
            end
            if (dn0 === 1'b1) ndone++;
            if (c == 10) d0 = 8'hFF;
            if (c == 38) d0 = 8'hC3;
            if (c == 42) v0 = 1'b0;
            if (c == 50) d0 = 8'hFF;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 2) begin
            n_bad++;
            $display("FAIL b2b_done_count got %0d want 2", ndone);
        end
        n_cmp++;
        if ({so0, rdy0} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_after got %b want 11", {so0, rdy0});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        int         ndone;
        exp   = 10'b1010101010;
        ndone = 0;
        @(negedge clk);
        d0 = 8'h00; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int c = 1; c < 18; c++) begin
            if (dn0 === 1'b1) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if (so0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_line_pre got %b want 0", so0);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({so0, rdy0, bsy0, dn0} !== 4'b1100) begin
            n_bad++;
            $display("FAIL mid_async got %b want 1100",
                     {so0, rdy0, bsy0, dn0});
        end
        @(negedge clk);
        if (dn0 === 1'b1) ndone++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dn0 === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0 || so0 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_no_done got done=%0d line=%b want 0 1",
                     ndone, so0);
        end
        d0 = 8'h55; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            n_cmp++;
            if ({so0, dn0} !== {exp[(c-1)/4], (c == 40)}) begin
                n_bad++;
                $display("FAIL mid_resend cyc %0d got %b want %b",
                         c, {so0, dn0}, {exp[(c-1)/4], (c == 40)});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_valid();
        logic [9:0] exp;
        int         ndone;
        exp   = 10'b1010110100;
        ndone = 0;
        @(negedge clk);
        d0 = 8'h5A; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            n_cmp++;
            if (c <= 40) begin
                if ({so0, rdy0} !== {exp[(c-1)/4], 1'b0}) begin
                    n_bad++;
                    $display("FAIL ign_frame cyc %0d got %b want %b",
                             c, {so0, rdy0}, {exp[(c-1)/4], 1'b0});
                end
            end else begin
                if ({so0, rdy0} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL ign_idle cyc %0d got %b want 11",
                             c, {so0, rdy0});
                end
            end
            if (dn0 === 1'b1) ndone++;
            v0 = (c == 5) || (c == 6) || (c == 20);
            d0 = 8'hFF;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL ign_done_count got %0d want 1", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_msb_first();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignored_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
